id_ex_forward: RTL

ID_EX_FORWARD -- requirements
Module: id_ex_forward

---
 rtl/id_ex_forward_pkg.sv | 26 ++
 rtl/id_ex_forward_fwd_mux.sv | 28 ++
 rtl/id_ex_forward.sv | 133 +++++++++++++
 3 files changed

// File: rtl/id_ex_forward_pkg.sv
// Shared processor definitions: ALU opcodes and the ID/EX control bubble.
package id_ex_forward_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   typedef struct packed {
      logic       valid;
      logic       alusrc;
      logic [2:0] aluop;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_BUBBLE = '{valid:    1'b0,
                                        alusrc:   1'b0,
                                        aluop:    ALU_AND,
                                        regwrite: 1'b0,
                                        memread:  1'b0,
                                        memwrite: 1'b0};

endpackage

// File: rtl/id_ex_forward_fwd_mux.sv
// Operand forwarding selector: EX/MEM beats MEM/WB beats register data; r0 reads as zero.
module fwd_mux #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic [REG_AW-1:0] src_addr_i,
   input  logic [DATA_W-1:0] reg_data_i,
   input  logic [REG_AW-1:0] exm_rd_i,
   input  logic              exm_regwrite_i,
   input  logic [DATA_W-1:0] exm_result_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_regwrite_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] fwd_data_o
);

   always_comb begin
      fwd_data_o = reg_data_i;
      if (src_addr_i == '0) begin
         fwd_data_o = '0;
      end else if (exm_regwrite_i && (exm_rd_i == src_addr_i)) begin
         fwd_data_o = exm_result_i;
      end else if (wb_regwrite_i && (wb_rd_i == src_addr_i)) begin
         fwd_data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with load-use stall detection and EX-stage operand forwarding.
module id_ex_forward
   import id_ex_forward_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alusrc,
   input  logic [2:0]        id_aluop,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              flush,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_regwrite,
   input  logic [DATA_W-1:0] exm_result,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] entrada1,
   output logic [DATA_W-1:0] entrada2,
   output logic [2:0]        ALUControl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_valid,
   output logic              stall
);

   ex_ctrl_t          ctrl_d, ctrl_q;
   logic [REG_AW-1:0] rs1_addr_d, rs1_addr_q;
   logic [REG_AW-1:0] rs2_addr_d, rs2_addr_q;
   logic [REG_AW-1:0] rd_addr_d, rd_addr_q;
   logic [DATA_W-1:0] rs1_data_d, rs1_data_q;
   logic [DATA_W-1:0] rs2_data_d, rs2_data_q;
   logic [DATA_W-1:0] imm_d, imm_q;
   logic [DATA_W-1:0] op_a, fwd_rs2;
   logic              load_use;

   // rs2 only counts as a consumer when it feeds the ALU or is the store data
   always_comb begin
      load_use = ctrl_q.valid && ctrl_q.memread && (rd_addr_q != '0) &&
                 ((rd_addr_q == id_rs1_addr) ||
                  ((rd_addr_q == id_rs2_addr) && (!id_alusrc || id_memwrite)));
      stall    = reset && !flush && id_valid && load_use;
   end

   always_comb begin
      ctrl_d     = CTRL_BUBBLE;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      if (!stall && !flush) begin
         ctrl_d     = '{valid: id_valid, alusrc: id_alusrc, aluop: id_aluop,
                        regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};
         rs1_addr_d = id_rs1_addr;
         rs2_addr_d = id_rs2_addr;
         rd_addr_d  = id_rd_addr;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ctrl_q     <= CTRL_BUBBLE;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
      end
   end

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
      .src_addr_i     (rs1_addr_q),
      .reg_data_i     (rs1_data_q),
      .exm_rd_i       (exm_rd),
      .exm_regwrite_i (exm_regwrite),
      .exm_result_i   (exm_result),
      .wb_rd_i        (wb_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_data_i      (wb_data),
      .fwd_data_o     (op_a)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
      .src_addr_i     (rs2_addr_q),
      .reg_data_i     (rs2_data_q),
      .exm_rd_i       (exm_rd),
      .exm_regwrite_i (exm_regwrite),
      .exm_result_i   (exm_result),
      .wb_rd_i        (wb_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_data_i      (wb_data),
      .fwd_data_o     (fwd_rs2)
   );

   assign entrada1      = op_a;
   assign entrada2      = ctrl_q.alusrc ? imm_q : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ALUControl    = ctrl_q.aluop;
   assign ex_rd_addr    = rd_addr_q;
   assign ex_regwrite   = ctrl_q.regwrite;
   assign ex_memread    = ctrl_q.memread;
   assign ex_memwrite   = ctrl_q.memwrite;
   assign ex_valid      = ctrl_q.valid;

endmodule
